// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-ported 256x16 data
// memory. Port 0 (CPU LSU) has priority; a saturating counter of consecutive
// port-0 wins while port 1 waits forces port 1 through every MAX_CONSEC+1
// cycles. Read data returns one cycle after the grant, steered to the port
// that issued the read.
module dmem_arbiter #(
    parameter int unsigned MAX_CONSEC = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [15:0] p0_addr,
    input  logic [15:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [15:0] p0_rdata,

    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [15:0] p1_addr,
    input  logic [15:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [15:0] p1_rdata,

    output logic [15:0] m_addr,
    output logic [15:0] m_wdata,
    output logic        m_write,
    output logic        m_read,
    input  logic [15:0] m_rdata
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_CONSEC);

    logic [3:0] consec_q, consec_d;
    logic [1:0] rsp_owner_q, rsp_owner_d;

    // Grant decision: port 0 wins ties unless port 1 has waited MAX_CONSEC grants.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!rst) begin
            if (p0_req && p1_req) begin
                if (consec_q == MAX_CNT) begin
                    p1_gnt = 1'b1;
                end else begin
                    p0_gnt = 1'b1;
                end
            end else begin
                p0_gnt = p0_req;
                p1_gnt = p1_req;
            end
        end
    end

    // Memory drive follows the winning port; all zero when nothing is granted.
    always_comb begin
        m_addr  = '0;
        m_wdata = '0;
        m_write = 1'b0;
        m_read  = 1'b0;
        if (p0_gnt) begin
            m_addr  = p0_addr;
            m_wdata = p0_wdata;
            m_write = p0_we;
            m_read  = ~p0_we;
        end else if (p1_gnt) begin
            m_addr  = p1_addr;
            m_wdata = p1_wdata;
            m_write = p1_we;
            m_read  = ~p1_we;
        end
    end

    // Next state: starvation counter and owner of next cycle's read data.
    always_comb begin
        consec_d = consec_q;
        if (p1_gnt || !p1_req) begin
            consec_d = '0;
        end else if (p0_gnt && (consec_q != MAX_CNT)) begin
            consec_d = consec_q + 4'd1;
        end
        rsp_owner_d = {p1_gnt & ~p1_we, p0_gnt & ~p0_we};
    end

    // State registers; reset also discards any outstanding read response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            consec_q    <= '0;
            rsp_owner_q <= '0;
        end else begin
            consec_q    <= consec_d;
            rsp_owner_q <= rsp_owner_d;
        end
    end

    // Return path: memory read data goes only to the port that owns it.
    always_comb begin
        p0_rvalid = rsp_owner_q[0];
        p1_rvalid = rsp_owner_q[1];
        p0_rdata  = rsp_owner_q[0] ? m_rdata : '0;
        p1_rdata  = rsp_owner_q[1] ? m_rdata : '0;
    end

endmodule
